// File: rtl/and_tree_stim_checker.sv
// and_tree_stim_checker: clocked stimulus generator and checker for a 4-input AND tree.
// Walks vec_idx 0..NUM_VEC-1 onto {a,b,c,d}. Each vector is held for HOLD_CYCLES
// cycles and then sampled for one more cycle. The tree return y_in is compared with &vec_idx.
// Optional macro AND_TREE_STIM_FIRST_FAIL_EN adds first_fail_vld / first_fail_idx.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle run request, accepted only when idle
//   a, b, c, d          tree inputs ({a,b,c,d} = vec_idx)
//   y_in                tree output, combinational return
//   busy, done, pass    run in progress, end-of-run pulse, last run clean
//   err_count           saturating mismatch count of current/last run
//   vec_idx             vector currently driven
module and_tree_stim_checker #(
  parameter int unsigned HOLD_CYCLES = 5,
  parameter int unsigned NUM_VEC     = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       vec_idx
`ifdef AND_TREE_STIM_FIRST_FAIL_EN
  ,
  output logic             first_fail_vld,
  output logic [3:0]       first_fail_idx
`endif
);

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned IDX_W  = 4;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  VEC_LAST  = IDX_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0]  ERR_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   vec_q, vec_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  // Low for the first edge after reset release so a start held across release is dropped.
  logic               arm_q;
  logic               mismatch;
`ifdef AND_TREE_STIM_FIRST_FAIL_EN
  logic               ffv_q, ffv_d;
  logic [IDX_W-1:0]   ffi_q, ffi_d;
`endif

  assign mismatch = y_in != (&vec_q);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      arm_q   <= 1'b0;
`ifdef AND_TREE_STIM_FIRST_FAIL_EN
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      arm_q   <= 1'b1;
`ifdef AND_TREE_STIM_FIRST_FAIL_EN
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
`ifdef AND_TREE_STIM_FIRST_FAIL_EN
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && arm_q) begin
          state_d = S_DRIVE;
          vec_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef AND_TREE_STIM_FIRST_FAIL_EN
          ffv_d   = 1'b0;
          ffi_d   = '0;
`endif
        end
      end
      S_DRIVE: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_LAST) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + CNT_W'(1);
          end
`ifdef AND_TREE_STIM_FIRST_FAIL_EN
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = vec_q;
          end
`endif
        end
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + IDX_W'(1);
          hold_d  = '0;
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The vector register drives the tree pins directly, so they are registered too.
  assign a         = vec_q[3];
  assign b         = vec_q[2];
  assign c         = vec_q[1];
  assign d         = vec_q[0];
  assign vec_idx   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef AND_TREE_STIM_FIRST_FAIL_EN
  assign first_fail_vld = ffv_q;
  assign first_fail_idx = ffi_q;
`endif

endmodule

// File: tb/tb_and_tree_stim_checker.sv
// Bench for and_tree_stim_checker. It keeps a cycle-count model of one run, which every
// cycle yields the expected vector, error count, busy, done and pass. Two small extra
// instances cover counter saturation and the single-vector case.
module tb_and_tree_stim_checker;

  localparam int H  = 5;
  localparam int N  = 16;
  localparam int CW = 8;
  localparam int T  = N * (H + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_s = 1'b0;
  int   mode = 0;   // 0: correct tree, 1: y stuck at 0, 2: y stuck at 1
  logic cmp_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic a, b, c, d, y_in, busy, done, pass;
  logic [CW-1:0] err_count;
  logic [3:0]    vec_idx;

  logic s_a, s_b, s_c, s_d, s_busy, s_done, s_pass;
  logic [1:0] s_err;
  logic [3:0] s_vec;
  logic o_a, o_b, o_c, o_d, o_busy, o_done, o_pass;
  logic [7:0] o_err;
  logic [3:0] o_vec;

`ifdef AND_TREE_STIM_FIRST_FAIL_EN
  logic       ffv, s_ffv, o_ffv;
  logic [3:0] ffi, s_ffi, o_ffi;
`endif

  always #5 clk = ~clk;

  // Tree emulation (or a stuck-at fault) closing the loop.
  assign y_in = (mode == 0) ? (a & b & c & d) : (mode == 2);

  and_tree_stim_checker #(.HOLD_CYCLES(H), .NUM_VEC(N), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .c(c), .d(d), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .vec_idx(vec_idx)
`ifdef AND_TREE_STIM_FIRST_FAIL_EN
    , .first_fail_vld(ffv), .first_fail_idx(ffi)
`endif
  );

  and_tree_stim_checker #(.HOLD_CYCLES(2), .NUM_VEC(16), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .a(s_a), .b(s_b), .c(s_c), .d(s_d), .y_in(1'b1),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err), .vec_idx(s_vec)
`ifdef AND_TREE_STIM_FIRST_FAIL_EN
    , .first_fail_vld(s_ffv), .first_fail_idx(s_ffi)
`endif
  );

  and_tree_stim_checker #(.HOLD_CYCLES(2), .NUM_VEC(1), .CNT_W(8)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .a(o_a), .b(o_b), .c(o_c), .d(o_d), .y_in(1'b0),
    .busy(o_busy), .done(o_done), .pass(o_pass), .err_count(o_err), .vec_idx(o_vec)
`ifdef AND_TREE_STIM_FIRST_FAIL_EN
    , .first_fail_vld(o_ffv), .first_fail_idx(o_ffi)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Vector j is sampled on edge (H+1)*(j+1) after the start edge; expected y is 1 only for 1111.
  function automatic bit mis(input int j, input int md);
    bit e;
    bit y;
    e = (j == 15);
    y = (md == 0) ? e : (md == 2);
    return y != e;
  endfunction

  function automatic int exp_err(input int k, input int md);
    int cnt = 0;
    for (int j = 0; j < N; j++)
      if ((H + 1) * (j + 1) <= k && mis(j, md)) cnt++;
    if (cnt > (1 << CW) - 1) cnt = (1 << CW) - 1;
    return cnt;
  endfunction

  function automatic int vec_at(input int k);
    int v;
    v = k / (H + 1);
    return (v > N - 1) ? N - 1 : v;
  endfunction

  function automatic int ff_at(input int k, input int md);
    for (int j = 0; j < N; j++)
      if ((H + 1) * (j + 1) <= k && mis(j, md)) return j;
    return -1;
  endfunction

  bit m_idle, m_done, m_pass, m_fresh, m_ffv;
  int m_k, m_mode, m_vec, m_err, m_ffi;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle <= 1'b1; m_done <= 1'b0; m_pass <= 1'b0; m_fresh <= 1'b1; m_ffv <= 1'b0;
      m_k <= 0; m_mode <= 0; m_vec <= 0; m_err <= 0; m_ffi <= 0;
    end else begin
      m_fresh <= 1'b0;
      m_done  <= 1'b0;
      if (m_idle) begin
        if (start && !m_fresh) begin
          m_idle <= 1'b0; m_k <= 0; m_mode <= mode; m_vec <= 0; m_err <= 0;
          m_pass <= 1'b0; m_ffv <= 1'b0; m_ffi <= 0;
        end
      end else if (m_k == T) begin
        m_idle <= 1'b1;
        m_done <= 1'b1;
        m_pass <= (m_err == 0);
      end else begin
        m_k   <= m_k + 1;
        m_vec <= vec_at(m_k + 1);
        m_err <= exp_err(m_k + 1, m_mode);
        if (ff_at(m_k + 1, m_mode) >= 0) begin
          m_ffv <= 1'b1;
          m_ffi <= ff_at(m_k + 1, m_mode);
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 32'(busy), 32'(!m_idle));
      check("done", 32'(done), 32'(m_done));
      check("pass", 32'(pass), 32'(m_pass));
      check("vec_idx", 32'(vec_idx), 32'(m_vec));
      check("abcd", 32'({a, b, c, d}), 32'(m_vec));
      check("err_count", 32'(err_count), 32'(m_err));
`ifdef AND_TREE_STIM_FIRST_FAIL_EN
      check("first_fail_vld", 32'(ffv), 32'(m_ffv));
      check("first_fail_idx", 32'(ffi), 32'(m_ffi));
`endif
    end
  end

  // One run on the main instance; optional stray starts at cycles 10 and 50.
  task automatic run_main(input bit extra, output int done_cyc, output int ndone);
    done_cyc = 0;
    ndone    = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 1; cyc <= 110; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      start = extra && (cyc == 9 || cyc == 49);
    end
    start = 1'b0;
  endtask

  int dc, nd, s_dc, o_dc;

  initial begin
    repeat (3) @(posedge clk);
    #1 cmp_en = 1'b1;
    // Start held while reset releases must be dropped.
    rst_n = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_at_release_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of vector 3.
    mode = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_pins", 32'({a, b, c, d, busy, done, pass}), 32'd0);
    check("rst_async_err", 32'(err_count), 32'd0);
    check("rst_async_vec", 32'(vec_idx), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Golden run with stray starts.
    run_main(1'b1, dc, nd);
    check("golden_done_cycle", 32'(dc), 32'd97);
    check("golden_done_count", 32'(nd), 32'd1);
    check("golden_pass", 32'(pass), 32'd1);
    check("golden_err", 32'(err_count), 32'd0);
    check("golden_last_vec", 32'(vec_idx), 32'd15);

    // y stuck at 0: only 1111 disagrees.
    mode = 1;
    run_main(1'b0, dc, nd);
    check("stuck0_done_count", 32'(nd), 32'd1);
    check("stuck0_err", 32'(err_count), 32'd1);
    check("stuck0_pass", 32'(pass), 32'd0);
`ifdef AND_TREE_STIM_FIRST_FAIL_EN
    check("stuck0_ff_vld", 32'(ffv), 32'd1);
    check("stuck0_ff_idx", 32'(ffi), 32'd15);
`endif

    // y stuck at 1: every vector except 1111 disagrees.
    mode = 2;
    run_main(1'b0, dc, nd);
    check("stuck1_err", 32'(err_count), 32'd15);
    check("stuck1_pass", 32'(pass), 32'd0);
`ifdef AND_TREE_STIM_FIRST_FAIL_EN
    check("stuck1_ff_idx", 32'(ffi), 32'd0);
`endif

    // Saturating 2-bit counter and the single-vector run.
    s_dc = 0;
    o_dc = 0;
    @(posedge clk); #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 16) check("sat_mid_err", 32'(s_err), 32'd3);
      if (s_done) s_dc = cyc;
      if (o_done) o_dc = cyc;
    end
    check("sat_done_cycle", 32'(s_dc), 32'd49);
    check("sat_final_err", 32'(s_err), 32'd3);
    check("sat_pass", 32'(s_pass), 32'd0);
    check("one_done_cycle", 32'(o_dc), 32'd4);
    check("one_vec", 32'(o_vec), 32'd0);
    check("one_pass", 32'(o_pass), 32'd1);
    check("one_err", 32'(o_err), 32'd0);
    check("one_busy", 32'(o_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
